// File: rtl/axi4lite_calc_slave_p.sv
// axi4lite_calc_slave_p: parametrised AXI4-Lite calculator slave.
// The register file holds A, B, OPCODE, RESULT (RO), MEM_SEL and memory words.
// STATUS sits at index NUM_REGS. A MUL takes DATA_W cycles and runs a shift-add.
// Build option: define CALC_IRQ_EN to add an IRQ output that mirrors STATUS.DONE.
module axi4lite_calc_slave_p #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int NUM_REGS  = 16,
  parameter int FIRST_MEM = 5
) (
  input  logic              A_CLK,
  input  logic              A_RST,
  input  logic              AW_VALID,
  output logic              AW_READY,
  input  logic [ADDR_W-1:0] AW_ADDR,
  input  logic              W_VALID,
  output logic              W_READY,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              B_VALID,
  input  logic              B_READY,
  output logic [1:0]        B_RESP,
  input  logic              AR_VALID,
  output logic              AR_READY,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              R_VALID,
  input  logic              R_READY,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP
`ifdef CALC_IRQ_EN
  , output logic            IRQ
`endif
);
  localparam int SH = $clog2(DATA_W/8);
  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] STAT_IDX = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] OPC_IDX  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] RES_IDX  = ADDR_W'(3);
  localparam logic [DATA_W-1:0] D_FIRST  = DATA_W'(FIRST_MEM);
  localparam logic [DATA_W-1:0] D_NREGS  = DATA_W'(NUM_REGS);
  localparam logic [DATA_W-1:0] D_MAXOP  = DATA_W'(10);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [3:0] OP_ADD = 4'd0, OP_AND = 4'd1, OP_OR  = 4'd2, OP_LDA = 4'd3,
                         OP_MADD = 4'd4, OP_MSUB = 4'd5, OP_MR = 4'd6, OP_MC = 4'd7,
                         OP_SUB = 4'd8, OP_XOR = 4'd9, OP_MUL = 4'd10;

  typedef enum logic {WIDLE, WRESP} wst_t;
  typedef enum logic {RIDLE, RDATA} rst_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  wst_t              r_wst;
  rst_t              r_rstate;
  logic              r_awready, r_wready, r_bvalid, r_aw_have, r_w_have;
  logic [1:0]        r_bresp, r_rresp;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_arready, r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy, r_carry, r_done, r_pend;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_opa, r_opb, r_mcand, r_mplier, r_acc;
  logic [IW-1:0]     r_sel;
  logic [CW-1:0]     r_cnt;

  logic [ADDR_W-1:0] w_aw_idx, w_ar_idx;
  logic              w_wr_err, w_op_go, w_memop, w_rd_err;
  logic [DATA_W:0]   w_add, w_sub;
  logic [DATA_W-1:0] w_acc_n, w_msel, w_rd_val, w_status;

  assign w_aw_idx = ADDR_W'(r_awaddr >> SH);
  assign w_ar_idx = ADDR_W'(AR_ADDR >> SH);
  assign w_memop  = (r_wdata >= DATA_W'(3)) && (r_wdata <= DATA_W'(7));
  assign w_add    = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_sub    = {1'b0, r_opa} - {1'b0, r_opb};
  assign w_acc_n  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_msel   = r_regs[r_sel];
  assign w_status = {{(DATA_W-3){1'b0}}, r_done, r_carry, r_busy};

  assign AW_READY = r_awready;
  assign W_READY  = r_wready;
  assign B_VALID  = r_bvalid;
  assign B_RESP   = r_bresp;
  assign AR_READY = r_arready;
  assign R_VALID  = r_rvalid;
  assign R_DATA   = r_rdata;
  assign R_RESP   = r_rresp;
`ifdef CALC_IRQ_EN
  assign IRQ = r_done;
`endif

  // Decode the latched write: error classification and whether it launches an op
  always_comb begin
    w_wr_err = 1'b0;
    w_op_go  = 1'b0;
    if (w_aw_idx > STAT_IDX || w_aw_idx == RES_IDX) w_wr_err = 1'b1;
    else if (w_aw_idx == OPC_IDX) begin
      if (r_busy || r_pend || r_wdata > D_MAXOP) w_wr_err = 1'b1;
      else if (w_memop && (r_regs[4] < D_FIRST || r_regs[4] >= D_NREGS)) w_wr_err = 1'b1;
      else w_op_go = 1'b1;
    end
  end

  // Read data mux: registers, STATUS, or SLVERR with zero data
  always_comb begin
    w_rd_val = '0;
    w_rd_err = 1'b0;
    if (w_ar_idx < STAT_IDX) w_rd_val = r_regs[w_ar_idx[IW-1:0]];
    else if (w_ar_idx == STAT_IDX) w_rd_val = w_status;
    else w_rd_err = 1'b1;
  end

  // Write FSM, register file and ALU; op updates come last so they win collisions
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wst <= WIDLE;
      r_awready <= 1'b0; r_wready <= 1'b0; r_bvalid <= 1'b0; r_bresp <= OKAY;
      r_aw_have <= 1'b0; r_w_have <= 1'b0; r_awaddr <= '0; r_wdata <= '0;
      r_busy <= 1'b0; r_carry <= 1'b0; r_done <= 1'b0; r_pend <= 1'b0;
      r_op <= '0; r_opa <= '0; r_opb <= '0; r_sel <= '0;
      r_mcand <= '0; r_mplier <= '0; r_acc <= '0; r_cnt <= '0;
    end else begin
      case (r_wst)
        WIDLE: begin
          if (r_aw_have && r_w_have) begin
            if (!w_wr_err) begin
              if (w_aw_idx == STAT_IDX) begin
                if (r_wdata[2]) r_done <= 1'b0;
              end else r_regs[w_aw_idx[IW-1:0]] <= r_wdata;
            end
            if (w_op_go) begin
              r_op  <= r_wdata[3:0];
              r_opa <= r_regs[0];
              r_opb <= r_regs[1];
              r_sel <= r_regs[4][IW-1:0];
              if (r_wdata[3:0] == OP_MUL) begin
                r_busy <= 1'b1; r_mcand <= r_regs[0]; r_mplier <= r_regs[1];
                r_acc <= '0; r_cnt <= CW'(DATA_W-1);
              end else r_pend <= 1'b1;
            end
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_err ? SLVERR : OKAY;
            r_wst     <= WRESP;
          end else begin
            if (!r_aw_have) begin
              if (AW_VALID && r_awready) begin
                r_awaddr <= AW_ADDR; r_aw_have <= 1'b1; r_awready <= 1'b0;
              end else r_awready <= 1'b1;
            end
            if (!r_w_have) begin
              if (W_VALID && r_wready) begin
                r_wdata <= W_DATA; r_w_have <= 1'b1; r_wready <= 1'b0;
              end else r_wready <= 1'b1;
            end
          end
        end
        WRESP: if (B_READY) begin
          r_bvalid <= 1'b0; r_bresp <= OKAY;
          r_awready <= 1'b1; r_wready <= 1'b1;
          r_wst <= WIDLE;
        end
        default: r_wst <= WIDLE;
      endcase

      if (r_pend) begin
        r_pend <= 1'b0;
        r_done <= 1'b1;
        case (r_op)
          OP_ADD:  begin r_regs[3] <= w_add[DATA_W-1:0]; r_carry <= w_add[DATA_W]; end
          OP_SUB:  begin r_regs[3] <= w_sub[DATA_W-1:0]; r_carry <= w_sub[DATA_W]; end
          OP_AND:  r_regs[3] <= r_opa & r_opb;
          OP_OR:   r_regs[3] <= r_opa | r_opb;
          OP_XOR:  r_regs[3] <= r_opa ^ r_opb;
          OP_LDA:  r_regs[0] <= w_msel;
          OP_MADD: r_regs[r_sel] <= w_msel + r_regs[3];
          OP_MSUB: r_regs[r_sel] <= w_msel - r_regs[3];
          OP_MR:   r_regs[3] <= w_msel;
          OP_MC:   r_regs[r_sel] <= '0;
          default: ;
        endcase
      end

      if (r_busy) begin
        r_acc    <= w_acc_n;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        if (r_cnt == '0) begin
          r_regs[3] <= w_acc_n; r_busy <= 1'b0; r_done <= 1'b1;
        end else r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Read FSM: data and response are captured when AR is accepted and held until R_READY
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      r_rstate <= RIDLE; r_arready <= 1'b0; r_rvalid <= 1'b0;
      r_rdata <= '0; r_rresp <= OKAY;
    end else begin
      case (r_rstate)
        RIDLE: begin
          if (AR_VALID && r_arready) begin
            r_rdata <= w_rd_val; r_rresp <= w_rd_err ? SLVERR : OKAY;
            r_rvalid <= 1'b1; r_arready <= 1'b0; r_rstate <= RDATA;
          end else r_arready <= 1'b1;
        end
        RDATA: if (R_READY) begin
          r_rvalid <= 1'b0; r_arready <= 1'b1; r_rstate <= RIDLE;
        end
        default: r_rstate <= RIDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_calc_slave_p.sv
// Directed bench for axi4lite_calc_slave_p with response/data scoreboards.
module tb_axi4lite_calc_slave_p;
  localparam int DW = 32, AWD = 8;
  localparam logic [1:0] OK = 2'b00, SE = 2'b10;
  localparam logic [AWD-1:0] RA = 8'h00, RB = 8'h04, ROP = 8'h08, RRES = 8'h0C,
                             RSEL = 8'h10, RM5 = 8'h14, RM15 = 8'h3C, RST = 8'h40;

  logic A_CLK = 1'b0, A_RST = 1'b1;
  logic AW_VALID = 0, AW_READY, W_VALID = 0, W_READY, B_VALID, B_READY = 0;
  logic AR_VALID = 0, AR_READY, R_VALID, R_READY = 0;
  logic [AWD-1:0] AW_ADDR = '0, AR_ADDR = '0;
  logic [DW-1:0]  W_DATA = '0, R_DATA;
  logic [1:0]     B_RESP, R_RESP;
`ifdef CALC_IRQ_EN
  logic IRQ;
`endif

  axi4lite_calc_slave_p dut (
`ifdef CALC_IRQ_EN
    .IRQ(IRQ),
`endif
    .A_CLK(A_CLK), .A_RST(A_RST),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  always #5 A_CLK = ~A_CLK;

  int n_chk = 0, n_fail = 0;
  typedef struct { logic [DW-1:0] d; logic [1:0] r; } exp_t;
  exp_t       rq[$];
  logic [1:0] bq[$];

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge A_CLK); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input string tag, input logic [AWD-1:0] a, input logic [DW-1:0] d,
                    input logic [1:0] er, input int lead = 0, input int bdel = 0);
    bit aw_hit, w_hit, tmo;
    int n;
    logic [1:0] resp;
    bq.push_back(er);
    W_DATA = d; W_VALID = 1; AW_ADDR = a; AW_VALID = (lead == 0);
    n = 0;
    while ((AW_VALID || W_VALID || n < lead) && n < 60) begin
      aw_hit = AW_VALID && AW_READY;
      w_hit  = W_VALID && W_READY;
      tick();
      n++;
      if (aw_hit) AW_VALID = 0;
      if (w_hit)  W_VALID = 0;
      if (lead > 0 && n == lead) begin
        chk({tag, "_no_early_b"}, B_VALID, 1'b0);
        AW_VALID = 1;
      end
    end
    tmo = AW_VALID || W_VALID;
    chk({tag, "_addr_tmo"}, tmo, 1'b0);
    AW_VALID = 0; W_VALID = 0;
    n = 0;
    while (!B_VALID && n < 60) begin tick(); n++; end
    tmo = !B_VALID;
    chk({tag, "_b_tmo"}, tmo, 1'b0);
    resp = B_RESP;
    for (int i = 0; i < bdel; i++) begin
      tick();
      chk({tag, "_b_hold_v"}, B_VALID, 1'b1);
      chk({tag, "_b_hold_r"}, B_RESP, resp);
    end
    B_READY = 1; tick(); B_READY = 0;
    chk({tag, "_b_drop"}, B_VALID, 1'b0);
    chk({tag, "_bresp"}, resp, bq.pop_front());
  endtask

  task automatic rd(input string tag, input logic [AWD-1:0] a, input logic [DW-1:0] ed,
                    input logic [1:0] er = 2'b00);
    exp_t e;
    bit hit, tmo;
    int n;
    logic [DW-1:0] d;
    logic [1:0] r;
    e.d = ed; e.r = er; rq.push_back(e);
    AR_ADDR = a; AR_VALID = 1; n = 0;
    while (AR_VALID && n < 60) begin
      hit = AR_READY;
      tick(); n++;
      if (hit) AR_VALID = 0;
    end
    AR_VALID = 0;
    n = 0;
    while (!R_VALID && n < 60) begin tick(); n++; end
    tmo = !R_VALID;
    chk({tag, "_r_tmo"}, tmo, 1'b0);
    d = R_DATA; r = R_RESP;
    R_READY = 1; tick(); R_READY = 0;
    e = rq.pop_front();
    chk({tag, "_data"}, d, e.d);
    chk({tag, "_rresp"}, r, e.r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_awready", AW_READY, 1'b0);
    chk("rst_arready", AR_READY, 1'b0);
    chk("rst_bvalid", B_VALID, 1'b0);
    chk("rst_rvalid", R_VALID, 1'b0);
    chk("rst_rdata", R_DATA, 32'h0);
    chk("rst_bresp", B_RESP, 2'b00);
    A_RST = 0;
    chk("ready_low_at_release", W_READY, 1'b0);
    tick();
    chk("awready_up", AW_READY, 1'b1);
    chk("wready_up", W_READY, 1'b1);
    chk("arready_up", AR_READY, 1'b1);

    // basic ALU
    wr("wA", RA, 50, OK); wr("wB", RB, 10, OK);
    wr("add", ROP, 0, OK);  rd("add_res", RRES, 60);
    wr("sub", ROP, 8, OK);  rd("sub_res", RRES, 40);
    wr("and", ROP, 1, OK);  rd("and_res", RRES, 2);
    rd("stat1", RST, 32'h4);
    wr("wA2", RA, 32'hFFFF_FFFF, OK); wr("wB2", RB, 1, OK);
    wr("addc", ROP, 0, OK); rd("addc_res", RRES, 0); rd("addc_st", RST, 32'h6);
    wr("wA3", RA, 0, OK);
    wr("subb", ROP, 8, OK); rd("subb_res", RRES, 32'hFFFF_FFFF); rd("subb_st", RST, 32'h6);
    wr("w1c1", RST, 4, OK); rd("w1c1_st", RST, 32'h2);

    // multiply
    wr("mA", RA, 1234, OK); wr("mB", RB, 5678, OK);
    wr("mul", ROP, 10, OK);
    rd("mul_busy", RST, 32'h3);
    wr("op_busy", ROP, 0, SE);
    wr("a_busy", RA, 7, OK);
    tick(40);
    rd("mul_res", RRES, 7006652);
    rd("mul_st", RST, 32'h6);
`ifdef CALC_IRQ_EN
    chk("irq_set", IRQ, 1'b1);
`endif
    rd("a_after", RA, 7);
    rd("op_after", ROP, 10);
    wr("w1c2", RST, 4, OK); rd("w1c2_st", RST, 32'h2);
`ifdef CALC_IRQ_EN
    chk("irq_clr", IRQ, 1'b0);
`endif

    // memory ops
    wr("mA15", RA, 15, OK); wr("mB0", RB, 0, OK);
    wr("add15", ROP, 0, OK); rd("add15_res", RRES, 15);
    wr("sel5", RSEL, 5, OK);
    wr("mp1", ROP, 4, OK); wr("mp2", ROP, 4, OK); rd("m5_30", RM5, 30);
    wr("mA8", RA, 8, OK); wr("add8", ROP, 0, OK); rd("add8_res", RRES, 8);
    wr("mm", ROP, 5, OK); rd("m5_22", RM5, 22);
    wr("mr", ROP, 6, OK); rd("mr_res", RRES, 22);
    wr("mc", ROP, 7, OK); rd("m5_0", RM5, 0);
    wr("m5w", RM5, 32'h55, OK);

    // error paths
    wr("sel2", RSEL, 2, OK);
    wr("memop_badsel", ROP, 4, SE);
    rd("m5_keep", RM5, 32'h55); rd("op_keep", ROP, 7);
    wr("bad_op", ROP, 15, SE); rd("op_keep2", ROP, 7);
    wr("wr_res", RRES, 32'h1234, SE); rd("res_keep", RRES, 22);
    rd("rd_bad", 8'h44, 0, SE);
    wr("wr_bad", 8'h48, 1, SE);
    wr("sel16", RSEL, 16, OK); wr("memop_sel16", ROP, 6, SE); rd("res_keep2", RRES, 22);
    wr("sel15", RSEL, 15, OK); wr("m15w", RM15, 9, OK);
    wr("mr15", ROP, 6, OK); rd("mr15_res", RRES, 9);
    rd("lowbits", 8'h03, 8);

    // handshakes
    wr("w_lead", RA, 99, OK, 3, 0); rd("w_lead_rd", RA, 99);
    wr("b_stall", RB, 3, OK, 0, 5); rd("b_stall_rd", RB, 3);

    // reset mid-MUL with a half-captured write pending
    wr("mul2", ROP, 10, OK);
    tick(3);
    W_DATA = 32'hDEAD; W_VALID = 1; tick(); W_VALID = 0;
    A_RST = 1; tick();
    chk("mr_awready", AW_READY, 1'b0);
    chk("mr_bvalid", B_VALID, 1'b0);
    A_RST = 0; tick(3);
    chk("mr_no_b", B_VALID, 1'b0);
    chk("mr_no_r", R_VALID, 1'b0);
    rd("mr_A", RA, 0); rd("mr_B", RB, 0); rd("mr_op", ROP, 0); rd("mr_res", RRES, 0);
    rd("mr_sel", RSEL, 0); rd("mr_m5", RM5, 0); rd("mr_m15", RM15, 0); rd("mr_st", RST, 0);
    wr("post_rst", RA, 5, OK); rd("post_rst_rd", RA, 5);
    rd("post_rst_b", RB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
